multicycle_ctrl: RTL and testbench

- Multi-cycle control FSM that sequences the RV32I datapath: instruction fetch, decode, execute, memory and writeback over several cycles.
- Drives the immediate generator's type select, ALU operand/op selects, PC/IR/register-file write enables and a shared instruction/data memory port with a req/ready handshake.
- Sits between the instruction register (opcode/funct fields) and the datapath muxes.

---
 rtl/multicycle_ctrl_pkg.sv | 95 +++++++++
 rtl/multicycle_ctrl_if.sv | 49 ++++
 rtl/multicycle_ctrl_alu_decoder.sv | 47 ++++
 rtl/multicycle_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv_ctrl_pkg
// Description : Shared encodings for the RV32I multi-cycle controller:
//               opcodes, FSM states, immediate-type selects, ALU operation
//               codes, PC-source and writeback-source selects, plus small
//               opcode classification helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package rv_ctrl_pkg;

    // RV32I major opcodes (IR[6:0])
    localparam logic [6:0] c_OPC_OP     = 7'b0110011;
    localparam logic [6:0] c_OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
    localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
    localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;

    // Controller states
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    // Immediate generator type select
    localparam logic [2:0] c_IMM_NONE = 3'b000;
    localparam logic [2:0] c_IMM_I    = 3'b001;
    localparam logic [2:0] c_IMM_S    = 3'b010;
    localparam logic [2:0] c_IMM_B    = 3'b011;
    localparam logic [2:0] c_IMM_U    = 3'b100;
    localparam logic [2:0] c_IMM_J    = 3'b101;

    // ALU operation codes
    localparam logic [3:0] c_ALU_ADD  = 4'd0;
    localparam logic [3:0] c_ALU_SUB  = 4'd1;
    localparam logic [3:0] c_ALU_SLL  = 4'd2;
    localparam logic [3:0] c_ALU_SLT  = 4'd3;
    localparam logic [3:0] c_ALU_SLTU = 4'd4;
    localparam logic [3:0] c_ALU_XOR  = 4'd5;
    localparam logic [3:0] c_ALU_SRL  = 4'd6;
    localparam logic [3:0] c_ALU_SRA  = 4'd7;
    localparam logic [3:0] c_ALU_OR   = 4'd8;
    localparam logic [3:0] c_ALU_AND  = 4'd9;

    // ALU operand selects
    localparam logic [1:0] c_ASEL_RS1  = 2'b00;
    localparam logic [1:0] c_ASEL_PC   = 2'b01;
    localparam logic [1:0] c_ASEL_ZERO = 2'b10;
    localparam logic       c_BSEL_RS2  = 1'b0;
    localparam logic       c_BSEL_IMM  = 1'b1;

    // PC source select
    localparam logic [1:0] c_PC_PLUS4  = 2'b00;
    localparam logic [1:0] c_PC_TARGET = 2'b01;
    localparam logic [1:0] c_PC_ALU    = 2'b10;

    // Writeback source select
    localparam logic [1:0] c_WB_ALU  = 2'b00;
    localparam logic [1:0] c_WB_MEM  = 2'b01;
    localparam logic [1:0] c_WB_PC4  = 2'b10;

    // Immediate format implied by the opcode; NONE for R-type and unknowns.
    function automatic logic [2:0] imm_sel_of(input logic [6:0] opc);
        logic [2:0] sel;
        case (opc)
            c_OPC_OP_IMM, c_OPC_LOAD, c_OPC_JALR: sel = c_IMM_I;
            c_OPC_STORE:                          sel = c_IMM_S;
            c_OPC_BRANCH:                         sel = c_IMM_B;
            c_OPC_LUI, c_OPC_AUIPC:               sel = c_IMM_U;
            c_OPC_JAL:                            sel = c_IMM_J;
            default:                              sel = c_IMM_NONE;
        endcase
        return sel;
    endfunction

    function automatic logic opcode_known(input logic [6:0] opc);
        logic known;
        case (opc)
            c_OPC_OP, c_OPC_OP_IMM, c_OPC_LOAD, c_OPC_STORE, c_OPC_BRANCH,
            c_OPC_JAL, c_OPC_JALR, c_OPC_LUI, c_OPC_AUIPC: known = 1'b1;
            default:                                       known = 1'b0;
        endcase
        return known;
    endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl_if
// Description : Bundle between the multi-cycle controller and the datapath /
//               shared memory port.
//   IR fields    : opcode[6:0], funct3[2:0], funct7_5, branch_taken
//   Memory       : mem_req, mem_we, mem_is_fetch (ctrl->mem), mem_ready
//   Datapath ctl : ir_write, pc_write, pc_src, imm_sel, alu_src_a,
//                  alu_src_b, alu_ctrl, reg_write, wb_sel
//   Status       : illegal, state (debug)
//   Modports     : slave = controller side, master = datapath/memory side
// Revision    : 1.0 - initial release
// ============================================================================
interface multicycle_ctrl_if;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       branch_taken;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_we;
    logic       mem_is_fetch;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic [2:0] imm_sel;
    logic [1:0] alu_src_a;
    logic       alu_src_b;
    logic [3:0] alu_ctrl;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic       illegal;
    logic [2:0] state;

    modport slave (
        input  opcode, funct3, funct7_5, branch_taken, mem_ready,
        output mem_req, mem_we, mem_is_fetch, ir_write, pc_write, pc_src,
               imm_sel, alu_src_a, alu_src_b, alu_ctrl, reg_write, wb_sel,
               illegal, state
    );

    modport master (
        output opcode, funct3, funct7_5, branch_taken, mem_ready,
        input  mem_req, mem_we, mem_is_fetch, ir_write, pc_write, pc_src,
               imm_sel, alu_src_a, alu_src_b, alu_ctrl, reg_write, wb_sel,
               illegal, state
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_ctrl_alu_decoder.sv
`default_nettype none
// ============================================================================
// Module      : alu_decoder
// Description : Maps opcode/funct3/funct7_5 to an ALU operation code.
//   opcode_i[6:0], funct3_i[2:0], funct7_5_i -> alu_ctrl_o[3:0]
//   R-type honours funct7_5 for SUB and SRA; I-type only for SRAI (ADDI
//   has no SUB form); branches compare with SUB; all else adds.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_decoder
    import rv_ctrl_pkg::*;
(
    input  wire logic [6:0] opcode_i,
    input  wire logic [2:0] funct3_i,
    input  wire logic       funct7_5_i,
    output logic      [3:0] alu_ctrl_o
);

    logic [3:0] w_funct_op;

    always_comb begin
        w_funct_op = c_ALU_ADD;
        case (funct3_i)
            3'b000: w_funct_op = c_ALU_ADD;
            3'b001: w_funct_op = c_ALU_SLL;
            3'b010: w_funct_op = c_ALU_SLT;
            3'b011: w_funct_op = c_ALU_SLTU;
            3'b100: w_funct_op = c_ALU_XOR;
            3'b101: w_funct_op = funct7_5_i ? c_ALU_SRA : c_ALU_SRL;
            3'b110: w_funct_op = c_ALU_OR;
            3'b111: w_funct_op = c_ALU_AND;
            default: w_funct_op = c_ALU_ADD;
        endcase
    end

    always_comb begin
        alu_ctrl_o = c_ALU_ADD;
        case (opcode_i)
            c_OPC_OP:     alu_ctrl_o = (funct3_i == 3'b000 && funct7_5_i) ? c_ALU_SUB : w_funct_op;
            c_OPC_OP_IMM: alu_ctrl_o = w_funct_op;
            c_OPC_BRANCH: alu_ctrl_o = c_ALU_SUB;
            default:      alu_ctrl_o = c_ALU_ADD;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl
// Description : RV32I multi-cycle control FSM (FETCH, DECODE, EXEC, MEM, WB,
//               TRAP). Outputs are combinational from the state register and
//               the IR fields; all outputs but state are held at 0 while rst.
//   clk, rst : clock (rising edge), synchronous active-high reset
//   bus      : multicycle_ctrl_if.slave (IR fields, memory handshake,
//              datapath selects/enables, illegal, debug state)
// Parameters  : RESET_STATE - state entered on reset
//               TRAP_STICKY - 1: TRAP holds until reset, 0: back to FETCH
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter state_t RESET_STATE = ST_FETCH,
    parameter bit     TRAP_STICKY = 1'b1
) (
    input  wire logic             clk,
    input  wire logic             rst,
    multicycle_ctrl_if.slave      bus
);

    state_t     state_q;
    state_t     state_d;

    logic       w_mem_req;
    logic       w_mem_we;
    logic       w_mem_is_fetch;
    logic       w_ir_write;
    logic       w_pc_write;
    logic [1:0] w_pc_src;
    logic [2:0] w_imm_sel;
    logic [1:0] w_alu_src_a;
    logic       w_alu_src_b;
    logic [3:0] w_alu_ctrl;
    logic       w_reg_write;
    logic [1:0] w_wb_sel;
    logic       w_illegal;
    logic [3:0] w_alu_dec;
    logic [2:0] w_imm_dec;

    alu_decoder u_alu_decoder (
        .opcode_i   (bus.opcode),
        .funct3_i   (bus.funct3),
        .funct7_5_i (bus.funct7_5),
        .alu_ctrl_o (w_alu_dec)
    );

    assign w_imm_dec = imm_sel_of(bus.opcode);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RESET_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        w_mem_req      = 1'b0;
        w_mem_we       = 1'b0;
        w_mem_is_fetch = 1'b0;
        w_ir_write     = 1'b0;
        w_pc_write     = 1'b0;
        w_pc_src       = c_PC_PLUS4;
        w_imm_sel      = c_IMM_NONE;
        w_alu_src_a    = c_ASEL_RS1;
        w_alu_src_b    = c_BSEL_RS2;
        w_alu_ctrl     = c_ALU_ADD;
        w_reg_write    = 1'b0;
        w_wb_sel       = c_WB_ALU;
        w_illegal      = 1'b0;

        case (state_q)
            ST_FETCH: begin
                w_mem_req      = 1'b1;
                w_mem_is_fetch = 1'b1;
                if (bus.mem_ready) begin
                    w_ir_write = 1'b1;
                    state_d    = ST_DECODE;
                end
            end

            ST_DECODE: begin
                if (opcode_known(bus.opcode)) begin
                    w_imm_sel = w_imm_dec;
                    state_d   = ST_EXEC;
                end else begin
                    w_illegal = 1'b1;
                    state_d   = ST_TRAP;
                end
            end

            ST_EXEC: begin
                w_imm_sel  = w_imm_dec;
                w_alu_ctrl = w_alu_dec;
                case (bus.opcode)
                    c_OPC_OP: state_d = ST_WB;
                    c_OPC_OP_IMM: begin
                        w_alu_src_b = c_BSEL_IMM;
                        state_d     = ST_WB;
                    end
                    c_OPC_LOAD, c_OPC_STORE: begin
                        w_alu_src_b = c_BSEL_IMM;
                        state_d     = ST_MEM;
                    end
                    c_OPC_BRANCH: begin
                        // Branch resolves here: PC updates without a WB state.
                        w_pc_write = 1'b1;
                        w_pc_src   = bus.branch_taken ? c_PC_TARGET : c_PC_PLUS4;
                        state_d    = ST_FETCH;
                    end
                    c_OPC_JAL: state_d = ST_WB;
                    c_OPC_JALR: begin
                        w_alu_src_b = c_BSEL_IMM;
                        state_d     = ST_WB;
                    end
                    c_OPC_LUI: begin
                        w_alu_src_a = c_ASEL_ZERO;
                        w_alu_src_b = c_BSEL_IMM;
                        state_d     = ST_WB;
                    end
                    c_OPC_AUIPC: begin
                        w_alu_src_a = c_ASEL_PC;
                        w_alu_src_b = c_BSEL_IMM;
                        state_d     = ST_WB;
                    end
                    default: begin
                        // IR was validated in DECODE; reaching here means
                        // the IR changed underneath us, so trap.
                        w_illegal = 1'b1;
                        state_d   = ST_TRAP;
                    end
                endcase
            end

            ST_MEM: begin
                // Address selects stay up so the ALU result remains stable
                // for the whole request.
                w_imm_sel      = w_imm_dec;
                w_mem_req      = 1'b1;
                w_mem_we       = (bus.opcode == c_OPC_STORE);
                w_alu_src_b    = c_BSEL_IMM;
                w_alu_ctrl     = w_alu_dec;
                if (bus.mem_ready) begin
                    if (bus.opcode == c_OPC_STORE) begin
                        w_pc_write = 1'b1;
                        state_d    = ST_FETCH;
                    end else begin
                        state_d    = ST_WB;
                    end
                end
            end

            ST_WB: begin
                w_imm_sel   = w_imm_dec;
                w_reg_write = 1'b1;
                w_pc_write  = 1'b1;
                case (bus.opcode)
                    c_OPC_LOAD: w_wb_sel = c_WB_MEM;
                    c_OPC_JAL: begin
                        w_wb_sel = c_WB_PC4;
                        w_pc_src = c_PC_TARGET;
                    end
                    c_OPC_JALR: begin
                        w_wb_sel = c_WB_PC4;
                        w_pc_src = c_PC_ALU;
                    end
                    default: w_wb_sel = c_WB_ALU;
                endcase
                state_d = ST_FETCH;
            end

            ST_TRAP: begin
                w_illegal = 1'b1;
                if (!TRAP_STICKY) begin
                    state_d = ST_FETCH;
                end
            end

            default: state_d = RESET_STATE;
        endcase
    end

    // Reset masks every output in the cycle it is seen so an in-flight
    // memory request is dropped immediately rather than one edge later.
    assign bus.mem_req      = rst ? 1'b0       : w_mem_req;
    assign bus.mem_we       = rst ? 1'b0       : w_mem_we;
    assign bus.mem_is_fetch = rst ? 1'b0       : w_mem_is_fetch;
    assign bus.ir_write     = rst ? 1'b0       : w_ir_write;
    assign bus.pc_write     = rst ? 1'b0       : w_pc_write;
    assign bus.pc_src       = rst ? 2'b00      : w_pc_src;
    assign bus.imm_sel      = rst ? c_IMM_NONE : w_imm_sel;
    assign bus.alu_src_a    = rst ? 2'b00      : w_alu_src_a;
    assign bus.alu_src_b    = rst ? 1'b0       : w_alu_src_b;
    assign bus.alu_ctrl     = rst ? 4'd0       : w_alu_ctrl;
    assign bus.reg_write    = rst ? 1'b0       : w_reg_write;
    assign bus.wb_sel       = rst ? 2'b00      : w_wb_sel;
    assign bus.illegal      = rst ? 1'b0       : w_illegal;
    assign bus.state        = state_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_ctrl
// Description : Self-checking bench for multicycle_ctrl. Each instruction is
//               expanded into a per-cycle schedule of inputs and expected
//               outputs (fetch waits, decode, execute, memory waits,
//               writeback, trap) and replayed against the DUT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

    localparam logic [6:0] c_OP = 7'b0110011, c_OPI = 7'b0010011, c_LD = 7'b0000011,
                           c_ST = 7'b0100011, c_BR  = 7'b1100011, c_JAL = 7'b1101111,
                           c_JALR = 7'b1100111, c_LUI = 7'b0110111, c_AUIPC = 7'b0010111;

    typedef struct {
        bit       rst, rdy, tk;
        bit [6:0] op;
        bit [2:0] f3;
        bit       f7;
        bit       st_dc, ill_dc;
        bit [2:0] st;
        bit       req, we, isf, irw, pcw;
        bit [1:0] pcs;
        bit [2:0] imm;
        bit [1:0] asrc;
        bit       bsrc;
        bit [3:0] alu;
        bit       rw;
        bit [1:0] wbs;
        bit       ill;
    } rec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_total = 0;
    int   n_bad   = 0;
    int   cyc     = 0;
    rec_t q[$];

    multicycle_ctrl_if bus ();

    multicycle_ctrl #(.TRAP_STICKY(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: run exceeded time budget (total=%0d bad=%0d)", n_total, n_bad);
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input int got, input int exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, cyc, got, exp);
        end
    endtask

    function automatic rec_t blank();
        rec_t r;
        r = '{default: 0};
        return r;
    endfunction

    function automatic bit known(input bit [6:0] op);
        return op inside {c_OP, c_OPI, c_LD, c_ST, c_BR, c_JAL, c_JALR, c_LUI, c_AUIPC};
    endfunction

    function automatic bit [2:0] exp_imm(input bit [6:0] op);
        if (op inside {c_OPI, c_LD, c_JALR}) return 3'd1;
        if (op == c_ST)                      return 3'd2;
        if (op == c_BR)                      return 3'd3;
        if (op inside {c_LUI, c_AUIPC})      return 3'd4;
        if (op == c_JAL)                     return 3'd5;
        return 3'd0;
    endfunction

    // ALU op from funct3 via a lookup of the spec's code table.
    function automatic bit [3:0] exp_alu(input bit [6:0] op, input bit [2:0] f3, input bit f7);
        int tbl [8];
        tbl = '{0, 2, 3, 4, 5, 6, 8, 9};
        if (op == c_BR) return 4'd1;
        if (op != c_OP && op != c_OPI) return 4'd0;
        if (f3 == 3'd5) return f7 ? 4'd7 : 4'd6;
        if (op == c_OP && f3 == 3'd0 && f7) return 4'd1;
        return 4'(tbl[f3]);
    endfunction

    function automatic rec_t base(input bit [31:0] ins);
        rec_t r;
        r     = blank();
        r.op  = ins[6:0];
        r.f3  = ins[14:12];
        r.f7  = ins[30];
        r.rdy = 1'($urandom_range(0, 1));
        r.tk  = 1'($urandom_range(0, 1));
        return r;
    endfunction

    task automatic push_instr(input bit [31:0] ins, input bit tk, input int wf,
                              input int wm, input bit rst_mem);
        rec_t r;
        bit [6:0] op;
        op = ins[6:0];
        // fetch: IR not valid yet, so feed unrelated fields
        for (int i = 0; i <= wf; i++) begin
            r = base($urandom);
            r.rdy = (i == wf); r.st = 3'd0; r.req = 1'b1; r.isf = 1'b1; r.irw = (i == wf);
            q.push_back(r);
        end
        r = base(ins); r.st = 3'd1; r.imm = exp_imm(op); r.ill_dc = 1'b1;
        q.push_back(r);
        if (!known(op)) begin
            for (int i = 0; i < 10; i++) begin
                r = base(ins); r.st = 3'd5; r.ill = 1'b1;
                q.push_back(r);
            end
            r = base(ins); r.rst = 1'b1; r.st = 3'd5;
            q.push_back(r);
            return;
        end
        r = base(ins); r.tk = tk; r.st = 3'd2; r.imm = exp_imm(op); r.alu = exp_alu(op, r.f3, r.f7);
        if (op inside {c_OPI, c_LD, c_ST, c_JALR, c_LUI, c_AUIPC}) r.bsrc = 1'b1;
        if (op == c_LUI)   r.asrc = 2'd2;
        if (op == c_AUIPC) r.asrc = 2'd1;
        if (op == c_BR) begin r.pcw = 1'b1; r.pcs = tk ? 2'd1 : 2'd0; end
        q.push_back(r);
        if (op == c_BR) return;
        if (op == c_LD || op == c_ST) begin
            for (int i = 0; i <= wm; i++) begin
                r = base(ins);
                if (rst_mem && i == 1) begin
                    r.rst = 1'b1; r.rdy = 1'b0; r.st = 3'd3;
                    q.push_back(r);
                    return;
                end
                r.rdy = (i == wm); r.st = 3'd3; r.req = 1'b1; r.we = (op == c_ST);
                r.bsrc = 1'b1; r.imm = exp_imm(op);
                r.pcw = (i == wm) && (op == c_ST);
                q.push_back(r);
            end
            if (op == c_ST) return;
        end
        r = base(ins); r.st = 3'd4; r.rw = 1'b1; r.pcw = 1'b1; r.imm = exp_imm(op);
        if (op == c_LD) r.wbs = 2'd1;
        if (op == c_JAL || op == c_JALR) r.wbs = 2'd2;
        if (op == c_JAL)  r.pcs = 2'd1;
        if (op == c_JALR) r.pcs = 2'd2;
        q.push_back(r);
    endtask

    task automatic run_queue();
        rec_t r;
        while (q.size() > 0) begin
            r = q.pop_front();
            @(negedge clk);
            cyc++;
            rst              = r.rst;
            bus.mem_ready    = r.rdy;
            bus.branch_taken = r.tk;
            bus.opcode       = r.op;
            bus.funct3       = r.f3;
            bus.funct7_5     = r.f7;
            #1;
            if (!r.st_dc)  check_val("state", int'(bus.state), int'(r.st));
            if (!r.ill_dc) check_val("illegal", int'(bus.illegal), int'(r.ill));
            check_val("mem_req",      int'(bus.mem_req),      int'(r.req));
            check_val("mem_we",       int'(bus.mem_we),       int'(r.we));
            check_val("mem_is_fetch", int'(bus.mem_is_fetch), int'(r.isf));
            check_val("ir_write",     int'(bus.ir_write),     int'(r.irw));
            check_val("pc_write",     int'(bus.pc_write),     int'(r.pcw));
            check_val("pc_src",       int'(bus.pc_src),       int'(r.pcs));
            check_val("imm_sel",      int'(bus.imm_sel),      int'(r.imm));
            check_val("alu_src_a",    int'(bus.alu_src_a),    int'(r.asrc));
            check_val("alu_src_b",    int'(bus.alu_src_b),    int'(r.bsrc));
            check_val("alu_ctrl",     int'(bus.alu_ctrl),     int'(r.alu));
            check_val("reg_write",    int'(bus.reg_write),    int'(r.rw));
            check_val("wb_sel",       int'(bus.wb_sel),       int'(r.wbs));
        end
    endtask

    initial begin
        rec_t r;
        bit [6:0] ops [9];
        bit [31:0] ins;
        bit [6:0] op;
        int wm;
        ops = '{c_OP, c_OPI, c_LD, c_ST, c_BR, c_JAL, c_JALR, c_LUI, c_AUIPC};
        bus.mem_ready = 1'b0; bus.branch_taken = 1'b0;
        bus.opcode = 7'd0; bus.funct3 = 3'd0; bus.funct7_5 = 1'b0;

        // reset: outputs quiet, then FETCH after the first edge
        r = blank(); r.rst = 1'b1; r.rdy = 1'b1; r.st_dc = 1'b1; q.push_back(r);
        r = blank(); r.rst = 1'b1; r.rdy = 1'b1; r.st = 3'd0;    q.push_back(r);
        run_queue();

        push_instr(32'h002081B3, 1'b0, 0, 0, 1'b0);   // ADD x3,x1,x2
        push_instr(32'h0000A103, 1'b0, 0, 3, 1'b0);   // LW x2,0(x1), 3 wait cycles
        push_instr(32'h00208463, 1'b1, 0, 0, 1'b0);   // BEQ taken
        push_instr(32'h00208463, 1'b0, 0, 0, 1'b0);   // BEQ not taken
        push_instr(32'h008280E7, 1'b0, 0, 0, 1'b0);   // JALR x1,8(x5)
        push_instr(32'h00000000, 1'b0, 0, 0, 1'b0);   // illegal -> sticky TRAP -> rst
        push_instr(32'h0020A023, 1'b0, 0, 3, 1'b1);   // SW, reset during MEM wait
        push_instr(32'h4020D193, 1'b0, 1, 0, 1'b0);   // SRAI
        push_instr(32'h402081B3, 1'b0, 0, 0, 1'b0);   // SUB
        push_instr(32'h40208193, 1'b0, 0, 0, 1'b0);   // ADDI with bit30 set -> ADD
        run_queue();

        for (int n = 0; n < 200; n++) begin
            ins = $urandom;
            op  = ops[$urandom_range(0, 8)];
            if ($urandom_range(0, 15) == 0) op = 7'h7F;
            ins[6:0] = op;
            wm = $urandom_range(0, 3);
            push_instr(ins, 1'($urandom_range(0, 1)), $urandom_range(0, 2), wm,
                       (wm >= 2) && ($urandom_range(0, 5) == 0));
            run_queue();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
